// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: pipeline-side and data-bus-side signals of the load/store sequencer.
interface lsu_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_re;
    logic                  mem_we;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  stall;
    logic                  done;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err_misaligned;
    logic                  err_illegal;
    logic                  err_timeout;
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [3:0]            bus_be;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic                  bus_gnt;
    logic                  bus_rvalid;
    logic [DATA_WIDTH-1:0] bus_rdata;
    modport master (
        input  mem_re, mem_we, funct3, addr, wdata, bus_gnt, bus_rvalid, bus_rdata,
        output stall, done, rdata, err_misaligned, err_illegal, err_timeout,
               bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
    modport slave (
        output mem_re, mem_we, funct3, addr, wdata, bus_gnt, bus_rvalid, bus_rdata,
        input  stall, done, rdata, err_misaligned, err_illegal, err_timeout,
               bus_req, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer driving a req/gnt/rvalid data bus and stalling the pipeline.
module lsu_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    lsu_ctrl_if.master    m
);
    typedef enum logic [2:0] {IDLE, REQ, RESP, DONE, ERR} state_t;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    state_t                state;
    logic [7:0]            cnt;
    logic                  req_q, we_q, done_q, e_mis, e_ill, e_to;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [3:0]            be_q, be_n;
    logic [DATA_WIDTH-1:0] wd_q, wd_n, rd_q, sh, ext;
    logic [2:0]            f3_q;
    logic                  ld_ok, st_ok, ill, mis;
    assign ld_ok = m.funct3 != 3'd3 && m.funct3[2:1] != 2'b11;
    assign st_ok = !m.funct3[2] && m.funct3[1:0] != 2'd3;
    assign ill   = (m.mem_re & m.mem_we) | (m.mem_re & !ld_ok) | (m.mem_we & !st_ok);
    assign mis   = (m.funct3[1:0] == 2'd1 && m.addr[0]) || (m.funct3[1:0] == 2'd2 && m.addr[1:0] != 2'd0);
    assign be_n  = m.funct3[1:0] == 2'd0 ? 4'b0001 << m.addr[1:0] :
                   m.funct3[1:0] == 2'd1 ? 4'b0011 << m.addr[1:0] : 4'b1111;
    assign wd_n  = m.funct3[1:0] == 2'd0 ? {4{m.wdata[7:0]}} :
                   m.funct3[1:0] == 2'd1 ? {2{m.wdata[15:0]}} : m.wdata;
    // Lane the addressed byte/half down to bit 0 before extending.
    assign sh    = m.bus_rdata >> {a_q[1:0], 3'b000};
    assign ext   = f3_q == 3'd0 ? {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]} :
                   f3_q == 3'd1 ? {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]} :
                   f3_q == 3'd4 ? {{(DATA_WIDTH-8){1'b0}}, sh[7:0]} :
                   f3_q == 3'd5 ? {{(DATA_WIDTH-16){1'b0}}, sh[15:0]} : sh;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            req_q  <= 1'b0;
            we_q   <= 1'b0;
            a_q    <= '0;
            be_q   <= '0;
            wd_q   <= '0;
            f3_q   <= '0;
            done_q <= 1'b0;
            rd_q   <= '0;
            e_mis  <= 1'b0;
            e_ill  <= 1'b0;
            e_to   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            rd_q   <= '0;
            e_mis  <= 1'b0;
            e_ill  <= 1'b0;
            e_to   <= 1'b0;
            case (state)
                IDLE: if (m.mem_re | m.mem_we) begin
                    if (ill | mis) begin
                        state  <= ERR;
                        done_q <= 1'b1;
                        e_ill  <= ill;
                        e_mis  <= !ill & mis;
                    end else begin
                        state <= REQ;
                        req_q <= 1'b1;
                        cnt   <= '0;
                        a_q   <= m.addr;
                        we_q  <= m.mem_we;
                        f3_q  <= m.funct3;
                        be_q  <= be_n;
                        wd_q  <= wd_n;
                    end
                end
                REQ: if (m.bus_gnt) begin
                    req_q <= 1'b0;
                    cnt   <= cnt + 8'd1;
                    if (we_q || m.bus_rvalid) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        rd_q   <= we_q ? '0 : ext;
                    end else state <= RESP;
                end else if (cnt == TO_LAST) begin
                    req_q  <= 1'b0;
                    state  <= ERR;
                    done_q <= 1'b1;
                    e_to   <= 1'b1;
                end else cnt <= cnt + 8'd1;
                RESP: if (m.bus_rvalid) begin
                    state  <= DONE;
                    done_q <= 1'b1;
                    rd_q   <= ext;
                end else if (cnt == TO_LAST) begin
                    state  <= ERR;
                    done_q <= 1'b1;
                    e_to   <= 1'b1;
                end else cnt <= cnt + 8'd1;
                default: state <= IDLE;
            endcase
        end
    end
    // Stall is combinational so the request is frozen in the very cycle it appears.
    assign m.stall          = !rst_i && (state == REQ || state == RESP || (state == IDLE && (m.mem_re || m.mem_we)));
    assign m.done           = done_q;
    assign m.rdata          = rd_q;
    assign m.err_misaligned = e_mis;
    assign m.err_illegal    = e_ill;
    assign m.err_timeout    = e_to;
    assign m.bus_req        = req_q;
    assign m.bus_we         = req_q & we_q;
    assign m.bus_addr       = req_q ? {a_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign m.bus_be         = req_q ? be_q : 4'b0000;
    assign m.bus_wdata      = req_q ? wd_q : '0;
endmodule
